// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and address helpers for the HD44780 responder.
package lcd_pkg;

  // Opcode masks; the highest set bit of an instruction byte selects the command.
  localparam logic [7:0] OP_SET_DDRAM  = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM  = 8'h40;
  localparam logic [7:0] OP_FUNC_SET   = 8'h20;
  localparam logic [7:0] OP_SHIFT      = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL  = 8'h08;
  localparam logic [7:0] OP_ENTRY_MODE = 8'h04;
  localparam logic [7:0] OP_HOME       = 8'h02;
  localparam logic [7:0] OP_CLEAR      = 8'h01;

  // DDRAM address map: two lines of 40 characters.
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE2_LAST = 7'h67;
  localparam int         NUM_CELLS  = 80;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic {ST_CLEAR, ST_IDLE} lcd_state_t;

  // Address counter step with the line wrap rule; inc=1 steps forward.
  function automatic logic [6:0] next_ac(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == LINE1_LAST)      r = LINE2_BASE;
      else if (ac == LINE2_LAST) r = LINE1_BASE;
      else                       r = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      r = LINE2_LAST;
      else if (ac == LINE2_BASE) r = LINE1_LAST;
      else                       r = ac - 7'd1;
    end
    return r;
  endfunction

  // True when the address maps onto a real display cell.
  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= LINE1_LAST) || ((a >= LINE2_BASE) && (a <= LINE2_LAST));
  endfunction

  // Linear cell index: line 2 starts at cell 40.
  function automatic logic [6:0] cell_idx(input logic [6:0] a);
    logic [6:0] base;
    base = a[6] ? 7'd40 : 7'd0;
    return base + {1'b0, a[5:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Shadow DDRAM: 80 x 8, one synchronous write port, one registered read port.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  input  logic       rvalid,
  output logic [7:0] rdata
);

  logic [7:0] mem [NUM_CELLS];

  // Write port; the caller only asserts we with an in-range cell index.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; out-of-map addresses return zero.
  always_ff @(posedge clk) begin
    rdata <= rvalid ? mem[raddr] : 8'h00;
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display-side HD44780 responder: decodes bit-banged bus writes, keeps a shadow
// DDRAM and cursor state, models busy timing and flags protocol violations.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES      = 40,
  parameter int BUSY_LONG_CYCLES = 1520
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_lcd_data,
  input  logic       i_lcd_rw,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_en,
  input  logic       i_lcd_on,
  output logic [7:0] o_lcd_rdata,
  input  logic [6:0] i_rd_addr,
  output logic [7:0] o_rd_char,
  output logic [6:0] o_cursor_addr,
  output logic [2:0] o_disp_ctrl,
  output logic       o_busy,
  output logic       o_wr_valid,
  output logic       o_wr_rs,
  output logic [7:0] o_wr_byte,
  output logic       o_err_busy,
  output logic       o_err_addr
);

  localparam int CNT_W = $clog2(BUSY_LONG_CYCLES + 1);

  lcd_state_t       state;
  logic [6:0]       clr_idx;
  logic [6:0]       ac;
  logic             inc;
  logic [CNT_W-1:0] busy_cnt;
  logic             en_q;

  logic             strobe;
  logic             host_we;
  logic             ram_we;
  logic [6:0]       ram_waddr;
  logic [7:0]       ram_wdata;

  assign o_busy        = (busy_cnt != '0);
  assign o_cursor_addr = ac;

  // Falling edge of EN with a write cycle on a powered bus.
  assign strobe  = en_q && !i_lcd_en && !i_lcd_rw && i_lcd_on && !i_reset;
  assign host_we = strobe && !o_busy && i_lcd_rs && addr_valid(ac);

  // Status read is combinational so the CPU sees it while holding EN high.
  assign o_lcd_rdata = (i_lcd_on && i_lcd_rw && i_lcd_en && !i_lcd_rs) ? {o_busy, ac} : 8'h00;

  // Clear sequence owns the write port; host writes are blocked by busy anyway.
  always_comb begin
    ram_we    = host_we;
    ram_waddr = cell_idx(ac);
    ram_wdata = i_lcd_data;
    if ((state == ST_CLEAR) && !i_reset) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = CHAR_SPACE;
    end
  end

  // Control FSM: clear sequencing, command decode, busy timing and error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_CLEAR;
      clr_idx     <= '0;
      ac          <= LINE1_BASE;
      inc         <= 1'b1;
      o_disp_ctrl <= 3'b000;
      o_wr_valid  <= 1'b0;
      o_err_busy  <= 1'b0;
      o_err_addr  <= 1'b0;
      busy_cnt    <= CNT_W'(BUSY_LONG_CYCLES);
      en_q        <= 1'b0;
    end else begin
      en_q       <= i_lcd_en;
      o_wr_valid <= 1'b0;
      if (busy_cnt != '0) busy_cnt <= busy_cnt - CNT_W'(1);

      if (state == ST_CLEAR) begin
        clr_idx <= clr_idx + 7'd1;
        if (clr_idx == 7'(NUM_CELLS - 1)) state <= ST_IDLE;
      end

      if (strobe) begin
        if (o_busy) begin
          o_err_busy <= 1'b1;
        end else if (i_lcd_rs && !addr_valid(ac)) begin
          o_err_addr <= 1'b1;
        end else begin
          o_wr_valid <= 1'b1;
          o_wr_rs    <= i_lcd_rs;
          o_wr_byte  <= i_lcd_data;
          if (i_lcd_rs) begin
            ac       <= next_ac(ac, inc);
            busy_cnt <= CNT_W'(BUSY_CYCLES);
          end else if ((i_lcd_data & OP_SET_DDRAM) != 8'h00) begin
            ac       <= i_lcd_data[6:0];
            busy_cnt <= CNT_W'(BUSY_CYCLES);
          end else if ((i_lcd_data & (OP_SET_CGRAM | OP_FUNC_SET)) != 8'h00) begin
            busy_cnt <= CNT_W'(BUSY_CYCLES);
          end else if ((i_lcd_data & OP_SHIFT) != 8'h00) begin
            // Display shift (S/C=1) has no shadow state to move.
            if (!i_lcd_data[3]) ac <= next_ac(ac, i_lcd_data[2]);
            busy_cnt <= CNT_W'(BUSY_CYCLES);
          end else if ((i_lcd_data & OP_DISP_CTRL) != 8'h00) begin
            o_disp_ctrl <= i_lcd_data[2:0];
            busy_cnt    <= CNT_W'(BUSY_CYCLES);
          end else if ((i_lcd_data & OP_ENTRY_MODE) != 8'h00) begin
            inc      <= i_lcd_data[1];
            busy_cnt <= CNT_W'(BUSY_CYCLES);
          end else if ((i_lcd_data & OP_HOME) != 8'h00) begin
            ac       <= LINE1_BASE;
            busy_cnt <= CNT_W'(BUSY_LONG_CYCLES);
          end else if ((i_lcd_data & OP_CLEAR) != 8'h00) begin
            state    <= ST_CLEAR;
            clr_idx  <= '0;
            ac       <= LINE1_BASE;
            inc      <= 1'b1;
            busy_cnt <= CNT_W'(BUSY_LONG_CYCLES);
          end
        end
      end
    end
  end

  lcd_ddram u_ddram (
    .clk    (i_clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr  (cell_idx(i_rd_addr)),
    .rvalid (addr_valid(i_rd_addr)),
    .rdata  (o_rd_char)
  );

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for the HD44780 responder: scoreboard of expected accepted writes plus
// directed reads of the shadow DDRAM and status outputs.
module tb_lcd_hd44780_responder;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_lcd_data;
  logic       i_lcd_rw, i_lcd_rs, i_lcd_en, i_lcd_on;
  logic [7:0] o_lcd_rdata;
  logic [6:0] i_rd_addr;
  logic [7:0] o_rd_char;
  logic [6:0] o_cursor_addr;
  logic [2:0] o_disp_ctrl;
  logic       o_busy, o_wr_valid, o_wr_rs, o_err_busy, o_err_addr;
  logic [7:0] o_wr_byte;

  always #5 clk = ~clk;

  lcd_hd44780_responder dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_lcd_data    (i_lcd_data),
    .i_lcd_rw      (i_lcd_rw),
    .i_lcd_rs      (i_lcd_rs),
    .i_lcd_en      (i_lcd_en),
    .i_lcd_on      (i_lcd_on),
    .o_lcd_rdata   (o_lcd_rdata),
    .i_rd_addr     (i_rd_addr),
    .o_rd_char     (o_rd_char),
    .o_cursor_addr (o_cursor_addr),
    .o_disp_ctrl   (o_disp_ctrl),
    .o_busy        (o_busy),
    .o_wr_valid    (o_wr_valid),
    .o_wr_rs       (o_wr_rs),
    .o_wr_byte     (o_wr_byte),
    .o_err_busy    (o_err_busy),
    .o_err_addr    (o_err_addr)
  );

  typedef struct packed {
    logic       rs;
    logic [7:0] b;
    logic [6:0] ac;
  } wr_exp_t;

  wr_exp_t sb[$];
  wr_exp_t mon_e;
  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int n_pushed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write pulse is matched against the oldest expected write.
  always @(negedge clk) begin
    if (o_wr_valid === 1'b1) begin
      n_pulses++;
      if (sb.size() == 0) begin
        chk("wr_unexpected_pulse", o_wr_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_rs", o_wr_rs, mon_e.rs);
        chk("wr_byte", o_wr_byte, mon_e.b);
        chk("wr_ac", o_cursor_addr, mon_e.ac);
      end
    end
  end

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    i_lcd_rs = rs; i_lcd_data = d; i_lcd_rw = 1'b0; i_lcd_en = 1'b1;
    @(negedge clk);
    i_lcd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (o_busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) chk("busy_timeout", o_busy, 1'b0);
  endtask

  task automatic push_exp(input logic rs, input logic [7:0] d, input logic [6:0] a);
    sb.push_back({rs, d, a});
    n_pushed++;
  endtask

  task automatic wr(input logic rs, input logic [7:0] d, input logic [6:0] a);
    int c;
    push_exp(rs, d, a);
    bus_write(rs, d);
    wait_idle(c);
  endtask

  task automatic check_char(input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    i_rd_addr = a;
    @(negedge clk);
    chk($sformatf("ddram_%02h", a), o_rd_char, exp);
  endtask

  task automatic status_probe(input logic [7:0] exp, input string tag);
    @(negedge clk);
    i_lcd_rs = 1'b0; i_lcd_rw = 1'b1; i_lcd_en = 1'b1;
    #1;
    chk(tag, o_lcd_rdata, exp);
    @(negedge clk);
    i_lcd_en = 1'b0;
    @(negedge clk);
    i_lcd_rw = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    i_reset = 1'b1; i_lcd_data = 8'h00; i_lcd_rw = 1'b0; i_lcd_rs = 1'b0;
    i_lcd_en = 1'b0; i_lcd_on = 1'b1; i_rd_addr = 7'h00;

    // Reset state and power-on clear timing
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 1'b1);
    chk("rst_ac", o_cursor_addr, 7'h00);
    chk("rst_disp", o_disp_ctrl, 3'b000);
    chk("rst_wr_valid", o_wr_valid, 1'b0);
    chk("rst_err_busy", o_err_busy, 1'b0);
    chk("rst_err_addr", o_err_addr, 1'b0);
    chk("rst_rdata", o_lcd_rdata, 8'h00);
    i_reset = 1'b0;
    wait_idle(cyc);
    chk("busy_len_reset", cyc, 1520);
    check_char(7'h00, 8'h20);
    check_char(7'h27, 8'h20);
    check_char(7'h40, 8'h20);
    check_char(7'h67, 8'h20);

    // Entry mode then two characters
    wr(1'b0, 8'h06, 7'h00);
    wr(1'b1, 8'h48, 7'h01);
    wr(1'b1, 8'h49, 7'h02);
    chk("t2_pulses", n_pulses, 3);
    check_char(7'h00, 8'h48);
    check_char(7'h01, 8'h49);
    chk("t2_ac", o_cursor_addr, 7'h02);
    wr(1'b0, 8'h0E, 7'h02);
    chk("disp_ctrl", o_disp_ctrl, 3'b110);
    status_probe(8'h02, "rdata_idle");

    // Line wrap forward
    wr(1'b0, 8'hA7, 7'h27);
    wr(1'b1, 8'h41, 7'h40);
    wr(1'b0, 8'hE7, 7'h67);
    wr(1'b1, 8'h42, 7'h00);
    check_char(7'h27, 8'h41);
    check_char(7'h67, 8'h42);

    // Decrement wrap backwards from 0x00
    wr(1'b0, 8'h04, 7'h00);
    wr(1'b0, 8'h80, 7'h00);
    wr(1'b1, 8'h5A, 7'h67);
    check_char(7'h00, 8'h5A);
    chk("t4_ac", o_cursor_addr, 7'h67);

    // Write while busy, then data at an unmapped address
    push_exp(1'b1, 8'h33, 7'h66);
    bus_write(1'b1, 8'h33);
    status_probe(8'hE6, "rdata_busy");
    repeat (7) @(negedge clk);
    chk("t5_busy_before", o_busy, 1'b1);
    bus_write(1'b1, 8'h44);
    chk("err_busy", o_err_busy, 1'b1);
    wait_idle(cyc);
    chk("t5_ac", o_cursor_addr, 7'h66);
    check_char(7'h66, 8'h20);
    check_char(7'h67, 8'h33);
    wr(1'b0, 8'hB0, 7'h30);
    chk("err_addr_before", o_err_addr, 1'b0);
    bus_write(1'b1, 8'h55);
    chk("err_addr", o_err_addr, 1'b1);
    chk("t5_ac_held", o_cursor_addr, 7'h30);
    chk("err_busy_sticky", o_err_busy, 1'b1);
    wait_idle(cyc);

    // Reset in the middle of a clear restarts the whole sequence
    push_exp(1'b0, 8'h01, 7'h00);
    bus_write(1'b0, 8'h01);
    repeat (40) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    chk("t6_ac", o_cursor_addr, 7'h00);
    chk("t6_err_busy", o_err_busy, 1'b0);
    chk("t6_err_addr", o_err_addr, 1'b0);
    chk("t6_busy", o_busy, 1'b1);
    i_reset = 1'b0;
    wait_idle(cyc);
    chk("busy_len_restart", cyc, 1520);
    check_char(7'h67, 8'h20);
    check_char(7'h66, 8'h20);
    check_char(7'h00, 8'h20);
    check_char(7'h27, 8'h20);
    check_char(7'h30, 8'h00);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("wr_pulses_total", n_pulses, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
